// File: rtl/sr_drv_pkg.sv
// Shared types for the SR latch driver: command encoding and FSM states.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'b00,
    CMD_RESET   = 2'b01,
    CMD_SET     = 2'b10,
    CMD_ILLEGAL = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_GAP   = 2'b10,
    ST_CHECK = 2'b11
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module sr_drv_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives S/R pulses into an external latch, then checks the latch read-back.
//
// state | meaning
// IDLE  | ready=1, waiting for req
// PULSE | s or r held high for PULSE_W cycles
// GAP   | s=r=0 for GAP_W cycles so the latch settles
// CHECK | done=1 for one cycle, err reports the read-back result
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] cmd,
  input  logic       q_fb,
  output logic       ready,
  output logic       s,
  output logic       r,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(max2(PULSE_W, GAP_W) + 1);
  localparam logic [CW-1:0] P_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_W - 1);

  generate
    if (PULSE_W < 1 || GAP_W < 1) begin : g_bad_param
      $error("sr_latch_driver: PULSE_W and GAP_W must both be >= 1");
    end
  endgenerate

  state_e        state;
  logic          expected;
  logic          tmr_load;
  logic          tmr_dec;
  logic          tmr_zero;
  logic [CW-1:0] tmr_val;

  // Counter is loaded with length-1 on entry, so zero marks the final cycle.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = P_LD;
    case (state)
      ST_IDLE:  tmr_load = req && ((cmd == CMD_SET) || (cmd == CMD_RESET));
      ST_PULSE: begin
        tmr_load = tmr_zero;
        tmr_val  = G_LD;
        tmr_dec  = !tmr_zero;
      end
      ST_GAP:   tmr_dec = !tmr_zero;
      default:  ;
    endcase
  end

  sr_drv_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      s        <= 1'b0;
      r        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ready    <= 1'b1;
      expected <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (cmd)
              CMD_SET: begin
                state    <= ST_PULSE;
                s        <= 1'b1;
                expected <= 1'b1;
              end
              CMD_RESET: begin
                state    <= ST_PULSE;
                r        <= 1'b1;
                expected <= 1'b0;
              end
              CMD_HOLD: begin
                // Expected is the current read-back, so HOLD completes clean.
                state    <= ST_CHECK;
                expected <= q_fb;
                done     <= 1'b1;
              end
              default: begin
                state <= ST_CHECK;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            state <= ST_GAP;
            s     <= 1'b0;
            r     <= 1'b0;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            state <= ST_CHECK;
            done  <= 1'b1;
            err   <= (q_fb != expected);
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench: latch model on s/r, schedule-based reference model, directed + random stimulus.
module tb_sr_latch_driver;
  import sr_drv_pkg::*;

  localparam int PW = 2;
  localparam int GW = 1;

  logic       clk = 1'b0;
  logic       rst, req, q_fb, ready, s, r, done, err;
  logic [1:0] cmd;
  logic       q_lat = 1'b0;
  logic       stuck;
  bit         chk_en = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .cmd   (cmd),
    .q_fb  (q_fb),
    .ready (ready),
    .s     (s),
    .r     (r),
    .done  (done),
    .err   (err)
  );

  // external latch driven by the DUT; stuck forces the read-back low
  always @(posedge clk) begin
    if (s === 1'b1)      q_lat <= 1'b1;
    else if (r === 1'b1) q_lat <= 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : q_lat;

  task automatic chk(input string nm, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, want);
    end
  endtask

  // Reference: each accepted command has a fixed schedule measured in
  // cycles since the acceptance edge (age).
  logic m_busy = 1'b0, m_exp = 1'b0, m_err = 1'b0;
  int   m_age = 0;
  logic [1:0] m_cmd = 2'b00;
  logic x_s, x_r, x_done, x_err, x_ready;

  always @(posedge clk) begin : model
    logic b, e, er;
    logic [1:0] c;
    int a, dl;
    b = m_busy; a = m_age; c = m_cmd; e = m_exp; er = m_err;
    if (!rst) begin
      m_busy <= 1'b0; m_age <= 0; m_err <= 1'b0;
      x_s <= 1'b0; x_r <= 1'b0; x_done <= 1'b0; x_err <= 1'b0; x_ready <= 1'b1;
    end else begin
      if (!b) begin
        if (req) begin
          b = 1'b1; a = 0; c = cmd; er = 1'b0;
          e = (cmd == CMD_SET);
          if (cmd == CMD_HOLD) e = q_fb;
        end
      end else begin
        a = a + 1;
      end
      dl = ((c == CMD_SET) || (c == CMD_RESET)) ? PW + GW : 0;
      x_s    <= b && (c == CMD_SET)   && (a < PW);
      x_r    <= b && (c == CMD_RESET) && (a < PW);
      x_done <= b && (a == dl);
      if (b && a == dl) er = (c == CMD_ILLEGAL) || (q_fb != e);
      if (b && a == dl + 1) b = 1'b0;
      x_ready <= !b;
      x_err   <= er;
      m_busy <= b; m_age <= a; m_cmd <= c; m_exp <= e; m_err <= er;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s", s, x_s);
      chk("r", r, x_r);
      chk("done", done, x_done);
      chk("err", err, x_err);
      chk("ready", ready, x_ready);
      chk("s_r_exclusive", s & r, 1'b0);
      assert (!(s === 1'b1 && r === 1'b1)) else $error("s and r both high");
    end
  end

  logic rs[1:10], rr[1:10], rd[1:10], re[1:10], ry[1:10];
  int   ndone;

  task automatic wait_ready();
    for (int k = 0; k < 20 && ready !== 1'b1; k++) @(negedge clk);
    chk("wait_ready", ready, 1'b1);
  endtask

  // Issue one command from a negedge with ready=1; record n following cycles.
  task automatic run_cmd(input logic [1:0] c, input int n, input bit poke);
    wait_ready();
    req = 1'b1; cmd = c;
    ndone = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) begin req = poke; cmd = 2'($urandom_range(0, 3)); end
      if (i == 2) req = 1'b0;
      rs[i] = s; rr[i] = r; rd[i] = done; re[i] = err; ry[i] = ready;
      if (done === 1'b1) ndone++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = 1'b1; cmd = CMD_SET; stuck = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_s", s, 1'b0); chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0); chk("rst_ready", ready, 1'b1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready, 1'b1); chk("post_rst_s", s, 1'b0);

    run_cmd(CMD_SET, 5, 1'b0);
    chk("set_s_e1", rs[1], 1'b1); chk("set_s_e2", rs[2], 1'b1);
    chk("set_s_e3", rs[3], 1'b0); chk("set_r_e3", rr[3], 1'b0);
    chk("set_done_e3", rd[3], 1'b0);
    chk("set_done_e4", rd[4], 1'b1); chk("set_err_e4", re[4], 1'b0);
    chk("set_ready_e4", ry[4], 1'b0);
    chk("set_ready_e5", ry[5], 1'b1); chk("set_done_e5", rd[5], 1'b0);
    chk("set_qfb", q_fb, 1'b1);

    run_cmd(CMD_RESET, 5, 1'b0);
    chk("rst_cmd_r_e1", rr[1], 1'b1); chk("rst_cmd_r_e2", rr[2], 1'b1);
    chk("rst_cmd_s_e1", rs[1], 1'b0); chk("rst_cmd_r_e3", rr[3], 1'b0);
    chk("rst_cmd_done_e4", rd[4], 1'b1); chk("rst_cmd_err_e4", re[4], 1'b0);
    chk("rst_cmd_qfb", q_fb, 1'b0);

    run_cmd(CMD_HOLD, 3, 1'b0);
    chk("hold_done_e1", rd[1], 1'b1); chk("hold_err_e1", re[1], 1'b0);
    chk("hold_s_e1", rs[1], 1'b0); chk("hold_r_e1", rr[1], 1'b0);
    chk("hold_ready_e2", ry[2], 1'b1);

    run_cmd(CMD_ILLEGAL, 3, 1'b0);
    chk("ill_done_e1", rd[1], 1'b1); chk("ill_err_e1", re[1], 1'b1);
    chk("ill_s_e1", rs[1], 1'b0); chk("ill_r_e1", rr[1], 1'b0);
    chk("ill_err_held_e2", re[2], 1'b1); chk("ill_ready_e2", ry[2], 1'b1);
    run_cmd(CMD_SET, 5, 1'b0);
    chk("err_cleared_e1", re[1], 1'b0);

    stuck = 1'b1;
    run_cmd(CMD_SET, 8, 1'b1);
    chk("stuck_done_e4", rd[4], 1'b1); chk("stuck_err_e4", re[4], 1'b1);
    chk("stuck_one_done", ndone == 1, 1'b1);
    stuck = 1'b0;

    wait_ready();
    req = 1'b1; cmd = CMD_SET;
    @(negedge clk); req = 1'b0;
    chk("abort_s_e1", s, 1'b1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("abort_s_dropped", s, 1'b0); chk("abort_done", done, 1'b0);
    rst = 1'b1;
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone == 0, 1'b1);
    chk("abort_ready", ready, 1'b1);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 59) != 0);
      req   = ($urandom_range(0, 2) == 0);
      cmd   = 2'($urandom_range(0, 3));
      stuck = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst = 1'b1; req = 1'b0; stuck = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
